account_ledger_responder: RTL



---
 rtl/atm_pkg.sv | 51 +++++
 rtl/acct_scan.sv | 45 ++++
 rtl/account_ledger_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger responder: operation and status
// codes, the fixed account-number table and the per-entry PIN table.
// No ports; imported by account_ledger_responder and acct_scan.
package atm_pkg;

  typedef enum logic [2:0] {
    OP_AUTH     = 3'd0,
    OP_BALANCE  = 3'd1,
    OP_DEBIT    = 3'd2,
    OP_CREDIT   = 3'd3,
    OP_TRANSFER = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_NO_ACCT  = 3'd1,
    ST_BAD_PIN  = 3'd2,
    ST_INSUFF   = 3'd3,
    ST_OVERFLOW = 3'd4,
    ST_NO_DEST  = 3'd5,
    ST_BAD_OP   = 3'd6
  } status_e;

  // Index width holds 0..TABLE_SIZE so the scanner can step one past the end.
  localparam int TABLE_SIZE = 10;
  localparam int IDX_W      = 4;

  function automatic logic [11:0] acct_at(input logic [IDX_W-1:0] idx);
    logic [11:0] num;
    case (idx)
      4'd0:    num = 12'd2749;
      4'd1:    num = 12'd2175;
      4'd2:    num = 12'd2429;
      4'd3:    num = 12'd2125;
      4'd4:    num = 12'd2178;
      4'd5:    num = 12'd2647;
      4'd6:    num = 12'd2816;
      4'd7:    num = 12'd2910;
      4'd8:    num = 12'd2299;
      4'd9:    num = 12'd2689;
      default: num = 12'd0;
    endcase
    return num;
  endfunction

  // Entry i carries PIN i.
  function automatic logic [3:0] pin_at(input logic [IDX_W-1:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/acct_scan.sv
// Sequential account-table scanner. One table entry is compared per cycle,
// lowest index first. After the last entry it spends one further cycle at
// index NUM_ACCTS to report a miss.
// Ports: clk, rst (sync, active high), start (restart scan at index 0),
// key (account number sought), done (result valid this cycle),
// found (key matched at index), index (current entry).
module acct_scan
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [11:0]      key,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_ACCTS);

  logic [IDX_W-1:0] idx;
  logic             busy;
  logic             hit;

  assign hit   = busy && (idx != END_IDX) && (acct_at(idx) == key);
  assign done  = busy && (hit || (idx == END_IDX));
  assign found = hit;
  assign index = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      idx  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= '0;
    end else if (busy) begin
      if (done) busy <= 1'b0;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/account_ledger_responder.sv
// Bank-side ledger responder. Accepts one request over req_valid/req_ready,
// scans for source (and destination) accounts, checks the PIN, applies the
// ledger update atomically and returns status and source balance over
// rsp_valid/rsp_ready.
// Ports: clk, rst (sync, active high); req_valid/req_ready handshake with
// req_op, req_acct, req_pin, req_dest, req_amount; rsp_valid/rsp_ready
// handshake with rsp_status, rsp_balance.
//
// state      | meaning
// S_IDLE     | ready for a request
// S_SRC      | scanning for the source account
// S_DST      | scanning for the destination account (transfer)
// S_EXEC     | PIN check and ledger update
// S_RESP     | response held until accepted
module account_ledger_responder
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS = 10,
  parameter int BAL_W     = 16,
  parameter int AMT_W     = 11,
  parameter int INIT_BAL  = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [11:0]      req_acct,
  input  logic [3:0]       req_pin,
  input  logic [11:0]      req_dest,
  input  logic [AMT_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance
);

  typedef enum logic [2:0] {S_IDLE, S_SRC, S_DST, S_EXEC, S_RESP} state_e;

  state_e state, state_nxt;

  logic [2:0]       op_q;
  logic [11:0]      acct_q, dest_q;
  logic [3:0]       pin_q;
  logic [AMT_W-1:0] amount_q;
  logic [IDX_W-1:0] src_idx, dst_idx;
  logic [BAL_W-1:0] bal [NUM_ACCTS];

  logic             accept, bad_op, scan_start, scan_done, scan_found;
  logic [11:0]      scan_key;
  logic [IDX_W-1:0] scan_index;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_ready && req_valid;
  assign bad_op    = (req_op > 3'd4);
  assign scan_key  = (state == S_DST) ? dest_q : acct_q;

  // The destination scan restarts on the same edge the source scan hits.
  assign scan_start = (accept && !bad_op) ||
                      (state == S_SRC && scan_done && scan_found && op_q == OP_TRANSFER);

  acct_scan #(.NUM_ACCTS(NUM_ACCTS)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .start (scan_start),
    .key   (scan_key),
    .done  (scan_done),
    .found (scan_found),
    .index (scan_index)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = bad_op ? S_RESP : S_SRC;
      S_SRC:  if (scan_done)
                state_nxt = !scan_found ? S_RESP :
                            (op_q == OP_TRANSFER) ? S_DST : S_EXEC;
      S_DST:  if (scan_done) state_nxt = scan_found ? S_EXEC : S_RESP;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ledger arithmetic; sums carry one extra bit so overflow never wraps.
  logic [BAL_W-1:0] amt_ext, src_bal, dst_bal, src_new, dst_new, ex_bal;
  logic [BAL_W:0]   src_sum, dst_sum;
  logic [2:0]       ex_status;
  logic             wr_src, wr_dst;

  assign amt_ext = {{(BAL_W-AMT_W){1'b0}}, amount_q};
  assign src_bal = bal[src_idx];
  assign dst_bal = bal[dst_idx];
  assign src_sum = {1'b0, src_bal} + {1'b0, amt_ext};
  assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_ext};

  always_comb begin
    ex_status = ST_OK;
    ex_bal    = src_bal;
    wr_src    = 1'b0;
    wr_dst    = 1'b0;
    src_new   = src_bal;
    dst_new   = dst_bal;
    if (pin_q != pin_at(src_idx)) begin
      ex_status = ST_BAD_PIN;
      ex_bal    = '0;
    end else begin
      case (op_q)
        OP_DEBIT:
          if (amt_ext > src_bal) ex_status = ST_INSUFF;
          else begin
            wr_src  = 1'b1;
            src_new = src_bal - amt_ext;
          end
        OP_CREDIT:
          if (src_sum[BAL_W]) ex_status = ST_OVERFLOW;
          else begin
            wr_src  = 1'b1;
            src_new = src_sum[BAL_W-1:0];
          end
        OP_TRANSFER:
          if (src_idx == dst_idx) ex_status = ST_OK;
          else if (amt_ext > src_bal) ex_status = ST_INSUFF;
          else if (dst_sum[BAL_W]) ex_status = ST_OVERFLOW;
          else begin
            wr_src  = 1'b1;
            wr_dst  = 1'b1;
            src_new = src_bal - amt_ext;
            dst_new = dst_sum[BAL_W-1:0];
          end
        default: ex_status = ST_OK;
      endcase
      ex_bal = src_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      acct_q      <= '0;
      dest_q      <= '0;
      pin_q       <= '0;
      amount_q    <= '0;
      src_idx     <= '0;
      dst_idx     <= '0;
      rsp_status  <= '0;
      rsp_balance <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) bal[i] <= BAL_W'(INIT_BAL);
    end else begin
      case (state)
        S_IDLE:
          if (accept) begin
            op_q     <= req_op;
            acct_q   <= req_acct;
            dest_q   <= req_dest;
            pin_q    <= req_pin;
            amount_q <= req_amount;
            if (bad_op) begin
              rsp_status  <= ST_BAD_OP;
              rsp_balance <= '0;
            end
          end
        S_SRC:
          if (scan_done) begin
            if (scan_found) src_idx <= scan_index;
            else begin
              rsp_status  <= ST_NO_ACCT;
              rsp_balance <= '0;
            end
          end
        S_DST:
          if (scan_done) begin
            if (scan_found) dst_idx <= scan_index;
            else begin
              rsp_status  <= ST_NO_DEST;
              rsp_balance <= '0;
            end
          end
        S_EXEC: begin
          rsp_status  <= ex_status;
          rsp_balance <= ex_bal;
          if (wr_src) bal[src_idx] <= src_new;
          if (wr_dst) bal[dst_idx] <= dst_new;
        end
        default: ;
      endcase
    end
  end

endmodule
